// File: rtl/display_scanner.sv
// Purpose : 14-bit score to 4-digit BCD (sequential double-dabble) with a multiplexed 7-segment scan.
// Latency : valid at edge k -> display digits and o_Busy=0 at edge k+15; scan step every REFRESH_DIV cycles.
// Backpressure: none; strobes arriving while busy collapse into one pending slot (last strobe wins).
module display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [13:0] i_Score,
  input  logic        i_Score_Valid,
  input  logic        i_Game_Over,
  output logic [7:0]  o_Digit,
  output logic [3:0]  o_Anode,
  output logic        o_Busy
);

  localparam int PW = 20;
  localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state;
  logic [13:0] bin;          // binary bits still to be shifted in, MSB first
  logic [15:0] bcd;          // conversion accumulator, four BCD nibbles
  logic [3:0]  shift_cnt;
  logic        pend_vld;
  logic [13:0] pend_val;
  logic [15:0] disp;         // committed digits; only ever written with a finished conversion

  logic [13:0] score_clamp;
  logic [15:0] bcd_adj;
  logic [31:0] codes;        // per-position digit codes, position 0 in bits [7:0]

  logic [PW-1:0] presc;
  logic [1:0]    scan_idx;
  logic [1:0]    idx_nxt;
  logic          scan_tick;

  // Scores above four decimal digits saturate to 9999
  always_comb begin
    score_clamp = (i_Score > 14'd9999) ? 14'd9999 : i_Score;
  end

  // Double-dabble correction: add 3 to every nibble >= 5 before it is shifted
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM; also owns the pending slot and the committed display digits
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      o_Busy    <= 1'b0;
      pend_vld  <= 1'b0;
      pend_val  <= '0;
      disp      <= '0;
    end else begin
      // A strobe during SHIFT or COMMIT is parked; IDLE consumes it directly
      if (i_Score_Valid && (state != IDLE)) begin
        pend_vld <= 1'b1;
        pend_val <= score_clamp;
      end
      case (state)
        IDLE: begin
          if (i_Score_Valid || pend_vld) begin
            bin       <= i_Score_Valid ? score_clamp : pend_val;
            bcd       <= '0;
            shift_cnt <= '0;
            o_Busy    <= 1'b1;
            pend_vld  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= 16'({bcd_adj, bin[13]});
          bin       <= {bin[12:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd13) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp   <= bcd;
          o_Busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit codes per position: LOSE override, else score with leading zeros blanked
  always_comb begin
    codes = {4{8'hFF}};
    if (i_Game_Over) begin
      codes = {8'h11, 8'h00, 8'h0A, 8'h0E};
    end else begin
      codes[7:0] = {4'h0, disp[3:0]};
      if (disp[15:4] != 12'd0) codes[15:8]  = {4'h0, disp[7:4]};
      if (disp[15:8] != 8'd0)  codes[23:16] = {4'h0, disp[11:8]};
      if (disp[15:12] != 4'd0) codes[31:24] = {4'h0, disp[15:12]};
    end
  end

  always_comb begin
    scan_tick = (presc == PRESC_TC);
    idx_nxt   = scan_idx + 2'd1;
  end

  // Free-running prescaler and scan; anode and digit step together on each tick
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      presc    <= '0;
      scan_idx <= 2'd3;
      o_Anode  <= 4'b1111;
      o_Digit  <= 8'hFF;
    end else if (scan_tick) begin
      presc    <= '0;
      scan_idx <= idx_nxt;
      o_Digit  <= codes[{idx_nxt, 3'b000} +: 8];
      case (idx_nxt)
        2'd0:    o_Anode <= 4'b1110;
        2'd1:    o_Anode <= 4'b1101;
        2'd2:    o_Anode <= 4'b1011;
        default: o_Anode <= 4'b0111;
      endcase
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Purpose : directed bench for display_scanner with an expected-display scoreboard.
// Latency : checks 15-cycle busy window and scan order at REFRESH_DIV=4.
// Backpressure: exercises the pending slot and reset abort.
module tb_display_scanner;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic [13:0] i_Score = '0;
  logic        i_Score_Valid = 1'b0;
  logic        i_Game_Over = 1'b0;
  logic [7:0]  o_Digit;
  logic [3:0]  o_Anode;
  logic        o_Busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] DISP_ZERO = {8'hFF, 8'hFF, 8'hFF, 8'h00};
  localparam logic [31:0] DISP_LOSE = {8'h11, 8'h00, 8'h0A, 8'h0E};

  display_scanner #(.REFRESH_DIV(4)) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Score      (i_Score),
    .i_Score_Valid(i_Score_Valid),
    .i_Game_Over  (i_Game_Over),
    .o_Digit      (o_Digit),
    .o_Anode      (o_Anode),
    .o_Busy       (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a one-cycle strobe at the current negedge and record the display it should produce
  task automatic send(input logic [13:0] score, input logic [31:0] expv);
    i_Score       = score;
    i_Score_Valid = 1'b1;
    exp_q.push_back(expv);
    @(negedge i_Clk);
    i_Score_Valid = 1'b0;
  endtask

  // Count negedges with o_Busy high, bounded
  task automatic wait_busy_low(input string tag, output int n);
    n = 0;
    while (o_Busy === 1'b1 && n < 64) begin
      n++;
      @(negedge i_Clk);
    end
    check({tag, " busy timeout"}, (n < 64) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic pop_exp(output logic [31:0] v);
    check("scoreboard nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    v = (exp_q.size() > 0) ? exp_q.pop_front() : DISP_ZERO;
  endtask

  // Observe the next four scan ticks and compare each lit position to the expected codes
  task automatic scan_check(input string tag, input logic [31:0] expv);
    logic [3:0] prev;
    int idx;
    int pidx;
    bit seen;
    pidx = -1;
    for (int t = 0; t < 4; t++) begin
      prev = o_Anode;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge i_Clk);
        if (o_Anode !== prev) begin
          seen = 1'b1;
          break;
        end
      end
      check({tag, " tick"}, {31'd0, seen}, 32'd1);
      case (o_Anode)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      check({tag, " anode onehot"}, (idx >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (pidx >= 0) check({tag, " scan order"}, idx, (pidx + 1) % 4);
      if (idx >= 0) check({tag, " digit"}, {24'd0, o_Digit}, {24'd0, expv[idx*8 +: 8]});
      pidx = idx;
    end
  endtask

  // Release reset at this negedge: blank for four cycles, then position 0 lit with 00
  task automatic release_check(input string tag);
    i_Reset = 1'b0;
    check({tag, " anode at release"}, {28'd0, o_Anode}, 32'hF);
    check({tag, " digit at release"}, {24'd0, o_Digit}, 32'hFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_Clk);
      check({tag, " anode blank"}, {28'd0, o_Anode}, 32'hF);
    end
    @(negedge i_Clk);
    check({tag, " first anode"}, {28'd0, o_Anode}, 32'hE);
    check({tag, " first digit"}, {24'd0, o_Digit}, 32'h00);
  endtask

  initial begin
    int n;
    logic [31:0] e;

    // Reset state
    repeat (2) @(negedge i_Clk);
    check("reset anode", {28'd0, o_Anode}, 32'hF);
    check("reset digit", {24'd0, o_Digit}, 32'hFF);
    check("reset busy", {31'd0, o_Busy}, 32'd0);
    release_check("por");
    scan_check("por scan", DISP_ZERO);

    // 1234: busy for exactly 15 cycles, then full 4-digit display
    send(14'd1234, {8'h01, 8'h02, 8'h03, 8'h04});
    check("1234 busy after strobe", {31'd0, o_Busy}, 32'd1);
    wait_busy_low("1234", n);
    check("1234 busy cycles", n, 15);
    pop_exp(e);
    scan_check("1234 scan", e);

    // Game over overrides the display while a conversion of 7 runs underneath
    i_Game_Over = 1'b1;
    send(14'd7, {8'hFF, 8'hFF, 8'hFF, 8'h07});
    wait_busy_low("7", n);
    check("7 busy cycles", n, 15);
    pop_exp(e);
    scan_check("lose scan", DISP_LOSE);
    i_Game_Over = 1'b0;
    scan_check("7 scan", e);

    // Saturation
    send(14'd12000, {8'h09, 8'h09, 8'h09, 8'h09});
    wait_busy_low("12000", n);
    check("12000 busy cycles", n, 15);
    pop_exp(e);
    scan_check("12000 scan", e);

    // 50 then 305 strobed at busy cycle 5: 50 commits first, 305 starts one cycle later
    send(14'd50, {8'hFF, 8'hFF, 8'h05, 8'h00});
    repeat (4) @(negedge i_Clk);
    send(14'd305, {8'hFF, 8'h03, 8'h00, 8'h05});
    wait_busy_low("50", n);
    check("50 remaining busy cycles", n, 10);
    @(negedge i_Clk);
    check("305 starts after commit", {31'd0, o_Busy}, 32'd1);
    pop_exp(e);
    scan_check("50 scan", e);
    wait_busy_low("305", n);
    pop_exp(e);
    scan_check("305 scan", e);

    // Reset at busy cycle 8 of 999 with a second value parked: both discarded
    send(14'd999, {8'hFF, 8'h09, 8'h09, 8'h09});
    repeat (3) @(negedge i_Clk);
    send(14'd888, {8'hFF, 8'h08, 8'h08, 8'h08});
    repeat (3) @(negedge i_Clk);
    check("999 busy before reset", {31'd0, o_Busy}, 32'd1);
    #1 i_Reset = 1'b1;
    #1;
    check("abort busy", {31'd0, o_Busy}, 32'd0);
    check("abort anode", {28'd0, o_Anode}, 32'hF);
    check("abort digit", {24'd0, o_Digit}, 32'hFF);
    exp_q.delete();
    exp_q.push_back(DISP_ZERO);
    @(negedge i_Clk);
    release_check("abort");
    pop_exp(e);
    scan_check("abort scan", e);
    check("no pending after reset", {31'd0, o_Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the i_Clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 i_Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 i_Reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 i_Score  input  14  SHALL be the unsigned binary score to display.
REQ-005 i_Score_Valid  input  1  SHALL be a one-cycle strobe marking i_Score as a new value.
REQ-006 i_Game_Over  input  1  SHALL be a level selecting the "LOSE" message instead of the score.
REQ-007 o_Digit  output  8  SHALL be the registered digit code for the 7-segment decoder (0x00-0x09 numerals, 0x0A S, 0x0E E, 0x11 L, 0xFF blank).
REQ-008 o_Anode  output  4  SHALL be the registered, active-low, one-hot digit enable; bit 0 is the rightmost digit.
REQ-009 o_Busy  output  1  SHALL be high while a binary-to-BCD conversion is in progress.

Function
REQ-010 An FSM with states IDLE, SHIFT and COMMIT SHALL perform a sequential double-dabble conversion.
REQ-011 In IDLE, i_Score_Valid=1 SHALL capture min(i_Score, 9999), clear the 16-bit BCD accumulator, enter SHIFT and set o_Busy on the same edge.
REQ-012 SHIFT SHALL run exactly 14 cycles, one bit per cycle, MSB first; before each shift it SHALL add 3 to every BCD nibble >= 5.
REQ-013 COMMIT SHALL run one cycle: it copies the accumulator into four display digit registers, clears o_Busy and returns to IDLE.
REQ-014 Latency: valid sampled at edge k -> display registers and o_Busy=0 both update at edge k+15; o_Busy is high for exactly 15 cycles.
REQ-015 i_Score_Valid while o_Busy=1 SHALL latch the value into a single pending register, with the last strobe winning; the FSM SHALL start it from IDLE on the cycle after COMMIT.
REQ-016 i_Score_Valid on the COMMIT cycle SHALL also be treated as pending.
REQ-017 Display registers SHALL never show a partially converted value.
REQ-018 A free-running prescaler SHALL count 0..REFRESH_DIV-1; at its terminal count the scan index (2-bit) SHALL advance and wrap 3->0.
REQ-019 On each scan tick, o_Anode SHALL drive only bit [index] low and o_Digit SHALL present that position's code; both SHALL change on the same edge.
REQ-020 Score mode: digits above the most significant nonzero digit SHALL be 0xFF (blanked); digit 0 SHALL always show its numeral, so score 0 displays "   0".
REQ-021 Game-over mode SHALL override the score with index3..0 = 0x11, 0x00, 0x0A, 0x0E ("LOSE"); the override takes effect on the next scan tick after i_Game_Over changes.
REQ-022 Conversion SHALL continue normally while i_Game_Over=1, and the new score SHALL appear once i_Game_Over falls.
REQ-023 The prescaler and scan SHALL be unaffected by conversion activity.

Reset
REQ-024 Asserting i_Reset SHALL immediately force o_Anode=4'b1111, o_Digit=8'hFF, o_Busy=0, FSM=IDLE, display digits=0, pending cleared, prescaler=0 and index=3.
REQ-025 After reset release, outputs SHALL stay blanked until the first scan tick, which lights index 0.
REQ-026 Reset during SHIFT or COMMIT SHALL abort the conversion; the display SHALL show 0 and no pending value SHALL survive.

Verification (REFRESH_DIV=4)
REQ-027 Reset, then release -> o_Anode=1111, o_Digit=FF for 4 cycles, then o_Anode=1110 with o_Digit=00.
REQ-028 Score 1234 with valid at edge k -> o_Busy high for cycles k..k+14; then the scan shows 04/03/02/01 on o_Anode 1110/1101/1011/0111.
REQ-029 Score 7 -> digit 0 shows 07 and digits 1-3 show FF; score 12000 -> displays 09,09,09,09.
REQ-030 i_Game_Over=1 -> anodes 0..3 show 0E, 0A, 00, 11; after deassertion the last committed score returns.
REQ-031 Score 50 then score 305, with the second valid at busy cycle 5 -> 50 commits first, the second conversion starts one cycle after COMMIT, and the final display is "305" with the leading digit blanked.
REQ-032 i_Reset pulse at busy cycle 8 of score 999 -> o_Busy drops asynchronously and the display shows "   0".
